aes_cmd_sched: RTL and testbench

AES_CMD_SCHED -- requirements
Module: aes_cmd_sched

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_cmd_sched.sv | 173 +++++++++++++++++
 tb/tb_aes_cmd_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES command scheduler: op codes, FSM states, block type.
package aes_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      OP_ENC = 2'b00,
      OP_DEC = 2'b01,
      OP_KEY = 2'b10,
      OP_ILL = 2'b11
   } aes_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } aes_state_e;

   // ENC and DEC are the only ops that run the core and therefore need a key.
   function automatic logic op_uses_core(input aes_op_e op);
      return (op == OP_ENC) || (op == OP_DEC);
   endfunction

endpackage

// File: rtl/aes_cmd_sched.sv
// Single-command scheduler in front of an AES core: accepts one ENC/DEC/KEY
// command, strobes the core, waits for completion with a timeout, and holds
// the response until it is consumed.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | ready for a command; rejected commands go straight to ST_RESP
//   ST_LOAD  | one-cycle load strobe (key, plaintext or ciphertext)
//   ST_START | one-cycle start strobe (enc or dec)
//   ST_WAIT  | waiting for the matching done flag, bounded by TIMEOUT_CYCLES
//   ST_RESP  | response held until rsp_ready
module aes_cmd_sched
   import aes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [127:0] cmd_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [127:0] rsp_data,
   output logic         rsp_err,
   output logic         core_set_key,
   output logic         core_set_plain_text,
   output logic         core_set_cipher_text,
   output logic [127:0] core_key,
   output logic [127:0] core_plain_text_in,
   output logic [127:0] core_cipher_text_in,
   output logic         core_start_enc,
   output logic         core_start_dec,
   input  logic         core_done_enc,
   input  logic         core_done_dec,
   input  logic [127:0] core_cipher_text_out,
   input  logic [127:0] core_plain_text_out
);

   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   aes_state_e       state;
   aes_state_e       state_nxt;
   aes_op_e          op_q;
   aes_block_t       data_q;
   logic             key_loaded;
   logic [CNT_W-1:0] wait_cnt;
   aes_block_t       rsp_data_q;
   logic             rsp_err_q;

   aes_op_e          cmd_op_e;
   logic             cmd_fire;
   logic             cmd_reject;
   logic             done_match;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             wait_timeout;
   logic             busy;

   assign cmd_op_e     = aes_op_e'(cmd_op);
   assign cmd_fire     = cmd_valid && cmd_ready;
   assign cmd_reject   = (cmd_op_e == OP_ILL) || (op_uses_core(cmd_op_e) && !key_loaded);
   // Only the flag belonging to the running op counts; the other is ignored.
   assign done_match   = (op_q == OP_ENC) ? core_done_enc : core_done_dec;
   // The count after this WAIT cycle; hitting the limit means TIMEOUT_CYCLES
   // WAIT cycles have elapsed without a done.
   assign wait_cnt_inc = wait_cnt + 1'b1;
   assign wait_timeout = (wait_cnt_inc == CNT_LIMIT);
   assign busy         = (state == ST_LOAD) || (state == ST_START) || (state == ST_WAIT);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (cmd_fire) begin
               state_nxt = cmd_reject ? ST_RESP : ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nxt = (op_q == OP_KEY) ? ST_RESP : ST_START;
         end
         ST_START: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_match || wait_timeout) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Command latch, key flag, WAIT counter and response capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q       <= OP_ENC;
         data_q     <= '0;
         key_loaded <= 1'b0;
         wait_cnt   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (cmd_fire) begin
            op_q   <= cmd_op_e;
            data_q <= cmd_data;
         end

         if ((state == ST_LOAD) && (op_q == OP_KEY)) begin
            key_loaded <= 1'b1;
         end

         if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt_inc;
         end else begin
            wait_cnt <= '0;
         end

         if ((state == ST_IDLE) && cmd_fire && cmd_reject) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end else if ((state == ST_LOAD) && (op_q == OP_KEY)) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
         end else if (state == ST_WAIT) begin
            if (done_match) begin
               rsp_data_q <= (op_q == OP_ENC) ? core_cipher_text_out : core_plain_text_out;
               rsp_err_q  <= 1'b0;
            end else if (wait_timeout) begin
               rsp_data_q <= '0;
               rsp_err_q  <= 1'b1;
            end
         end
      end
   end

   // Handshake, strobe and operand outputs decoded from the state.
   always_comb begin
      rsp_valid            = (state == ST_RESP);
      cmd_ready            = (state == ST_IDLE) && !rsp_valid;
      rsp_data             = rsp_valid ? rsp_data_q : '0;
      rsp_err              = rsp_valid && rsp_err_q;

      core_set_key         = (state == ST_LOAD)  && (op_q == OP_KEY);
      core_set_plain_text  = (state == ST_LOAD)  && (op_q == OP_ENC);
      core_set_cipher_text = (state == ST_LOAD)  && (op_q == OP_DEC);
      core_start_enc       = (state == ST_START) && (op_q == OP_ENC);
      core_start_dec       = (state == ST_START) && (op_q == OP_DEC);

      core_key             = (busy && (op_q == OP_KEY)) ? data_q : '0;
      core_plain_text_in   = (busy && (op_q == OP_ENC)) ? data_q : '0;
      core_cipher_text_in  = (busy && (op_q == OP_DEC)) ? data_q : '0;
   end

endmodule

// File: tb/tb_aes_cmd_sched.sv
// Bench for aes_cmd_sched: directed vector table, randomized commands against
// a command-level reference model, and a reset-during-WAIT sequence. The AES
// core is a behavioural stand-in that knows the FIPS-197 example vector and
// otherwise applies an invertible mixing function.
`timescale 1ns/1ps
module tb_aes_cmd_sched;
   import aes_pkg::*;

   localparam int           TMO = 8;
   localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P0  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C0  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] MIX = 128'h5ac3_96e1_0f1e_2d3c_4b5a_6978_8796_a5b4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [127:0] cmd_data;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [127:0] rsp_data;
   logic         rsp_err;
   logic         core_set_key, core_set_plain_text, core_set_cipher_text;
   logic [127:0] core_key, core_plain_text_in, core_cipher_text_in;
   logic         core_start_enc, core_start_dec;
   logic         core_done_enc, core_done_dec;
   logic [127:0] core_cipher_text_out, core_plain_text_out;

   always #5 clk = ~clk;

   aes_cmd_sched #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .cmd_valid            (cmd_valid),
      .cmd_ready            (cmd_ready),
      .cmd_op               (cmd_op),
      .cmd_data             (cmd_data),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_data             (rsp_data),
      .rsp_err              (rsp_err),
      .core_set_key         (core_set_key),
      .core_set_plain_text  (core_set_plain_text),
      .core_set_cipher_text (core_set_cipher_text),
      .core_key             (core_key),
      .core_plain_text_in   (core_plain_text_in),
      .core_cipher_text_in  (core_cipher_text_in),
      .core_start_enc       (core_start_enc),
      .core_start_dec       (core_start_dec),
      .core_done_enc        (core_done_enc),
      .core_done_dec        (core_done_dec),
      .core_cipher_text_out (core_cipher_text_out),
      .core_plain_text_out  (core_plain_text_out)
   );

   function automatic logic [127:0] stub_enc(input logic [127:0] k, input logic [127:0] p);
      if (k == K0 && p == P0) return C0;
      return p ^ {k[63:0], k[127:64]} ^ MIX;
   endfunction

   function automatic logic [127:0] stub_dec(input logic [127:0] k, input logic [127:0] c);
      if (k == K0 && c == C0) return P0;
      return c ^ {k[63:0], k[127:64]} ^ MIX;
   endfunction

   // ---------------- core stand-in ----------------
   // lat_cfg = number of cycles after START before done; 0 means never.
   int           lat_cfg;
   logic [127:0] ck, cpt, cct;
   int           enc_cnt, dec_cnt;
   logic         enc_busy, dec_busy;

   // Core behaviour evaluated on the falling edge, away from the DUT's edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         core_done_enc        <= 1'b0;
         core_done_dec        <= 1'b0;
         core_cipher_text_out <= '0;
         core_plain_text_out  <= '0;
         enc_busy             <= 1'b0;
         dec_busy             <= 1'b0;
         enc_cnt              <= 0;
         dec_cnt              <= 0;
      end else begin
         if (core_set_key)         ck  <= core_key;
         if (core_set_plain_text)  cpt <= core_plain_text_in;
         if (core_set_cipher_text) cct <= core_cipher_text_in;
         if (core_start_enc) begin
            core_done_enc <= 1'b0;
            enc_cnt       <= lat_cfg;
            enc_busy      <= (lat_cfg != 0);
         end else if (enc_busy) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1) begin
               core_done_enc        <= 1'b1;
               core_cipher_text_out <= stub_enc(ck, cpt);
               enc_busy             <= 1'b0;
            end
         end
         if (core_start_dec) begin
            core_done_dec <= 1'b0;
            dec_cnt       <= lat_cfg;
            dec_busy      <= (lat_cfg != 0);
         end else if (dec_busy) begin
            dec_cnt <= dec_cnt - 1;
            if (dec_cnt == 1) begin
               core_done_dec       <= 1'b1;
               core_plain_text_out <= stub_dec(ck, cct);
               dec_busy            <= 1'b0;
            end
         end
      end
   end

   // ---------------- strobe monitor ----------------
   // bit 0 set_key, 1 set_plain, 2 set_cipher, 3 start_enc, 4 start_dec
   wire logic [4:0] strb = {core_start_dec, core_start_enc, core_set_cipher_text,
                            core_set_plain_text, core_set_key};
   logic [4:0]   prev_strb = '0;
   int           strb_cnt [5] = '{0, 0, 0, 0, 0};
   int           viol_multi  = 0;
   int           viol_consec = 0;
   logic [127:0] last_key = '0, last_pt = '0, last_ct = '0;

   // Count strobes, record operands at each strobe, flag overlap/stretching.
   always @(negedge clk) begin
      prev_strb <= strb;
      if ($countones(strb) > 1) viol_multi <= viol_multi + 1;
      if ((strb & prev_strb) != 5'b0) viol_consec <= viol_consec + 1;
      for (int i = 0; i < 5; i++) if (strb[i]) strb_cnt[i] <= strb_cnt[i] + 1;
      if (strb[0]) last_key <= core_key;
      if (strb[1]) last_pt  <= core_plain_text_in;
      if (strb[2]) last_ct  <= core_cipher_text_in;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " rsp_valid/err"}, {rsp_valid, rsp_err}, 2'b00);
      check({tag, " rsp_data"}, rsp_data, 128'h0);
      check({tag, " strobes"}, strb, 5'b0);
      check({tag, " core_key"}, core_key, 128'h0);
      check({tag, " core_plain_text_in"}, core_plain_text_in, 128'h0);
      check({tag, " core_cipher_text_in"}, core_cipher_text_in, 128'h0);
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [127:0] data;
      int           lat;
      int           hold;
      logic         exp_err;
      logic [127:0] exp_data;
      int           exp_lat;
      logic [4:0]   exp_strb;
   } vec_t;

   // Reference model state: what the scheduler should know about the key.
   logic         m_key_loaded = 1'b0;
   logic [127:0] m_key = '0;

   // Expected outcome of one command from the command-level rules.
   function automatic vec_t model_expect(input vec_t v);
      vec_t r = v;
      if (v.op == OP_ILL || (v.op != OP_KEY && !m_key_loaded)) begin
         r.exp_err = 1'b1; r.exp_data = '0; r.exp_lat = 1; r.exp_strb = 5'b0;
      end else if (v.op == OP_KEY) begin
         r.exp_err = 1'b0; r.exp_data = '0; r.exp_lat = 2; r.exp_strb = 5'b00001;
      end else begin
         r.exp_strb = (v.op == OP_ENC) ? 5'b01010 : 5'b10100;
         if (v.lat >= 1 && v.lat <= TMO) begin
            r.exp_err  = 1'b0;
            r.exp_data = (v.op == OP_ENC) ? stub_enc(m_key, v.data) : stub_dec(m_key, v.data);
            r.exp_lat  = 3 + v.lat;
         end else begin
            r.exp_err  = 1'b1;
            r.exp_data = '0;
            r.exp_lat  = 3 + TMO;
         end
      end
      return r;
   endfunction

   string strb_name [5] = '{"set_key count", "set_plain_text count", "set_cipher_text count",
                            "start_enc count", "start_dec count"};

   task automatic run_cmd(input vec_t v);
      int           n;
      int           s0 [5];
      int           m0, c0;
      logic [127:0] hd;
      logic         he;
      lat_cfg = v.lat;
      @(negedge clk);
      for (int i = 0; i < 5; i++) s0[i] = strb_cnt[i];
      m0 = viol_multi;
      c0 = viol_consec;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_data  = v.data;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready for new command", cmd_ready, 1'b1);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("response latency", n, v.exp_lat);
      check("rsp_err", rsp_err, v.exp_err);
      check("rsp_data", rsp_data, v.exp_data);
      check("cmd_ready low in RESP", cmd_ready, 1'b0);
      hd = rsp_data;
      he = rsp_err;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         check("held rsp_data", rsp_data, hd);
         check("held valid/err/ready", {rsp_valid, rsp_err, cmd_ready}, {1'b1, he, 1'b0});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("after consume valid/ready", {rsp_valid, cmd_ready}, 2'b01);
      for (int i = 0; i < 5; i++) check(strb_name[i], strb_cnt[i] - s0[i], 128'(v.exp_strb[i]));
      check("overlapping strobes", viol_multi - m0, 0);
      check("stretched strobes", viol_consec - c0, 0);
      if (v.exp_strb[0]) check("key at set_key", last_key, v.data);
      if (v.exp_strb[1]) check("plaintext at set_plain_text", last_pt, v.data);
      if (v.exp_strb[2]) check("ciphertext at set_cipher_text", last_ct, v.data);
   endtask

   vec_t dir [11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   r;

      dir[0]  = '{OP_ENC, P0, 3, 0, 1'b1, 128'h0, 1,  5'b00000};
      dir[1]  = '{OP_ILL, P0, 3, 0, 1'b1, 128'h0, 1,  5'b00000};
      dir[2]  = '{OP_KEY, K0, 0, 1, 1'b0, 128'h0, 2,  5'b00001};
      dir[3]  = '{OP_ENC, P0, 3, 0, 1'b0, C0,     6,  5'b01010};
      dir[4]  = '{OP_DEC, C0, 1, 2, 1'b0, P0,     4,  5'b10100};
      dir[5]  = '{OP_ENC, P0, 8, 0, 1'b0, C0,     11, 5'b01010};
      dir[6]  = '{OP_ENC, P0, 0, 5, 1'b1, 128'h0, 11, 5'b01010};
      dir[7]  = '{OP_DEC, C0, 9, 0, 1'b1, 128'h0, 11, 5'b10100};
      dir[8]  = '{OP_ILL, K1, 2, 0, 1'b1, 128'h0, 1,  5'b00000};
      dir[9]  = '{OP_KEY, K1, 0, 0, 1'b0, 128'h0, 2,  5'b00001};
      dir[10] = '{OP_ENC, P0, 2, 0, 1'b0, stub_enc(K1, P0), 5, 5'b01010};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = '0;
      rsp_ready = 1'b0;
      lat_cfg   = 1;
      repeat (3) @(negedge clk);
      check_zero("in reset");
      reset_n = 1'b1;
      @(negedge clk);
      check("cmd_ready first clock after reset", cmd_ready, 1'b1);

      for (int i = 0; i < 11; i++) begin
         run_cmd(dir[i]);
         if (dir[i].op == OP_KEY) begin
            m_key_loaded = 1'b1;
            m_key        = dir[i].data;
         end
      end

      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         v.op   = (r < 3) ? OP_ENC : (r < 6) ? OP_DEC : (r < 8) ? OP_KEY : OP_ILL;
         v.data = {$urandom(), $urandom(), $urandom(), $urandom()};
         if ($urandom_range(0, 4) == 0) v.data = (v.op == OP_KEY) ? K0 : (v.op == OP_DEC) ? C0 : P0;
         v.lat  = int'($urandom_range(0, 10));
         v.hold = int'($urandom_range(0, 3));
         v = model_expect(v);
         run_cmd(v);
         if (v.op == OP_KEY) begin
            m_key_loaded = 1'b1;
            m_key        = v.data;
         end
      end

      v = '{OP_KEY, K0, 0, 0, 1'b0, 128'h0, 0, 5'b0};
      v = model_expect(v);
      run_cmd(v);
      m_key_loaded = 1'b1;
      m_key        = K0;

      lat_cfg = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_ENC;
      cmd_data  = P0;
      check("cmd_ready before reset test", cmd_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("plaintext operand during WAIT", core_plain_text_in, P0);
      #2 reset_n = 1'b0;
      #1 check_zero("reset in WAIT");
      @(negedge clk);
      check_zero("held in reset");
      reset_n      = 1'b1;
      m_key_loaded = 1'b0;
      @(negedge clk);
      check("cmd_ready after mid-op reset", cmd_ready, 1'b1);

      v = '{OP_ENC, P0, 2, 0, 1'b0, 128'h0, 0, 5'b0};
      v = model_expect(v);
      run_cmd(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
